coproc_ctrl_param: RTL and testbench

//   Parametrised sequencer for the matrix coprocessor. On each start edge it fetches operands A/B

---
 rtl/coproc_ctrl_param_if.sv | 42 ++++
 rtl/coproc_ctrl_param.sv | 158 +++++++++++++++
 tb/tb_coproc_ctrl_param.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/coproc_ctrl_param_if.sv
`default_nettype none
// ============================================================================
// Module      : coproc_ctrl_param_if
// Description : Bus bundle between the coprocessor sequencer and its
//               neighbours: operand fetch handshake with the matrix manager,
//               ALU launch/completion, and result write-back handshake.
//               master = sequencer side, slave = matrix manager / ALU side.
// Signals     : rd_req/rd_ack, mat_a_in, mat_b_in     operand fetch
//               alu_start, alu_op, alu_a, alu_b        ALU launch
//               alu_done, alu_res                      ALU completion
//               wr_req/wr_ack, mat_res                 result write-back
// Revision    : 1.0 - initial release
// ============================================================================
interface coproc_ctrl_param_if #(
  parameter int MAT_W = 225,
  parameter int OP_W  = 3
) ();
  logic             rd_req;
  logic             rd_ack;
  logic [MAT_W-1:0] mat_a_in;
  logic [MAT_W-1:0] mat_b_in;
  logic             alu_start;
  logic [OP_W-1:0]  alu_op;
  logic [MAT_W-1:0] alu_a;
  logic [MAT_W-1:0] alu_b;
  logic             alu_done;
  logic [MAT_W-1:0] alu_res;
  logic             wr_req;
  logic             wr_ack;
  logic [MAT_W-1:0] mat_res;

  modport master (
    output rd_req, alu_start, alu_op, alu_a, alu_b, wr_req, mat_res,
    input  rd_ack, mat_a_in, mat_b_in, alu_done, alu_res, wr_ack
  );

  modport slave (
    input  rd_req, alu_start, alu_op, alu_a, alu_b, wr_req, mat_res,
    output rd_ack, mat_a_in, mat_b_in, alu_done, alu_res, wr_ack
  );
endinterface
`default_nettype wire

// File: rtl/coproc_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : coproc_ctrl_param
// Description : Sequencer for the matrix coprocessor. A rising edge on sinal
//               starts one operation: validate opcode, fetch operands A/B,
//               launch the ALU, wait for completion under a watchdog, write
//               the result back and report status.
// Ports       : clk, rst (async, active high)
//               sinal     in   start level (rising edge = request)
//               operacao  in   opcode, sampled when the start is accepted
//               busy      out  high while not idle
//               done_o    out  one-cycle pulse at end of every operation
//               erro      out  00 ok / 01 bad opcode / 10 ALU timeout (sticky)
//               op_count  out  successful operations, wraps at 256
//               leds      out  {state, erro, mat_res[3:0]}
//               bus       master side of coproc_ctrl_param_if
// Revision    : 1.0 - initial release
// ============================================================================
module coproc_ctrl_param #(
  parameter int N       = 5,
  parameter int ELEM_W  = 9,
  parameter int OP_W    = 3,
  parameter int NUM_OPS = 7,
  parameter int TIMEOUT = 1023
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            sinal,
  input  wire logic [OP_W-1:0] operacao,
  output logic                 busy,
  output logic                 done_o,
  output logic [1:0]           erro,
  output logic [7:0]           op_count,
  output logic [8:0]           leds,
  coproc_ctrl_param_if.master  bus
);

  localparam int MAT_W   = N * N * ELEM_W;
  // Timer only ever has to reach TIMEOUT-1; keep at least one bit.
  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [31:0]        OPS_LIMIT  = 32'(NUM_OPS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_LAUNCH   = 3'd2,
    S_WAIT_ALU = 3'd3,
    S_WRITE    = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  state_t               state;
  logic                 sinal_d;
  logic                 start_p;
  logic [TIMER_W-1:0]   timer;

  // Every output is registered and updated together with the state it
  // belongs to, so each branch below sets the outputs of the state it enters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      sinal_d       <= 1'b0;
      start_p       <= 1'b0;
      timer         <= '0;
      busy          <= 1'b0;
      done_o        <= 1'b0;
      erro          <= 2'b00;
      op_count      <= 8'd0;
      bus.rd_req    <= 1'b0;
      bus.alu_start <= 1'b0;
      bus.alu_op    <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.wr_req    <= 1'b0;
      bus.mat_res   <= '0;
    end else begin
      sinal_d       <= sinal;
      start_p       <= sinal & ~sinal_d;
      // Pulse outputs default low; the entering branch raises them.
      alu_start_clr();
      case (state)
        S_IDLE: begin
          // start_p seen in any other state is simply dropped.
          if (start_p) begin
            bus.alu_op <= operacao;
            busy       <= 1'b1;
            if (32'(operacao) >= OPS_LIMIT) begin
              erro   <= 2'b01;
              done_o <= 1'b1;
              state  <= S_ERR;
            end else begin
              erro       <= 2'b00;
              bus.rd_req <= 1'b1;
              state      <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (bus.rd_ack) begin
            bus.alu_a     <= bus.mat_a_in;
            bus.alu_b     <= bus.mat_b_in;
            bus.rd_req    <= 1'b0;
            bus.alu_start <= 1'b1;
            state         <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          timer <= '0;
          state <= S_WAIT_ALU;
        end
        S_WAIT_ALU: begin
          // Completion wins over the watchdog in the expiry cycle.
          if (bus.alu_done) begin
            bus.mat_res <= bus.alu_res;
            bus.wr_req  <= 1'b1;
            state       <= S_WRITE;
          end else if (timer == TIMER_LAST) begin
            erro   <= 2'b10;
            done_o <= 1'b1;
            state  <= S_ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WRITE: begin
          if (bus.wr_ack) begin
            bus.wr_req <= 1'b0;
            done_o     <= 1'b1;
            op_count   <= op_count + 8'd1;
            state      <= S_DONE;
          end
        end
        S_DONE, S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy       <= 1'b0;
          bus.rd_req <= 1'b0;
          bus.wr_req <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  // Clears the single-cycle pulses at the start of every clocked update.
  task automatic alu_start_clr();
    bus.alu_start <= 1'b0;
    done_o        <= 1'b0;
  endtask

  assign leds = {state, erro, bus.mat_res[3:0]};

endmodule
`default_nettype wire

// File: tb/tb_coproc_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_coproc_ctrl_param
// Description : Directed testbench for coproc_ctrl_param. A reactive slave
//               answers the fetch / ALU / write handshakes with programmable
//               delays; expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coproc_ctrl_param;

  localparam int MAT_W = 225;
  localparam logic [MAT_W-1:0] C_A    = {25{9'h0A5}};
  localparam logic [MAT_W-1:0] C_B    = {25{9'h15A}};
  localparam logic [MAT_W-1:0] C_RES1 = {25{9'h1C3}};
  localparam logic [MAT_W-1:0] C_RES2 = {25{9'h0F6}};

  logic       clk;
  logic       rst;
  logic       sinal;
  logic [2:0] operacao;
  logic       busy;
  logic       done_o;
  logic [1:0] erro;
  logic [7:0] op_count;
  logic [8:0] leds;

  coproc_ctrl_param_if #(.MAT_W(MAT_W), .OP_W(3)) bus ();

  coproc_ctrl_param dut (
    .clk      (clk),
    .rst      (rst),
    .sinal    (sinal),
    .operacao (operacao),
    .busy     (busy),
    .done_o   (done_o),
    .erro     (erro),
    .op_count (op_count),
    .leds     (leds),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Results of the most recent run_op.
  int         d_cyc;
  int         d_n;
  int         al_n;
  int         rd_n;
  int         wr_n;
  int         res_bad;
  logic [8:0] leds_d;
  logic [1:0] erro_d;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation. Cycle c=0 is when sinal rises; start_p is high in c=1.
  // rd/wr acks arrive once the request has been high for more than *_dly
  // cycles; alu_done rises alu_dly cycles after WAIT_ALU is entered
  // (alu_dly < 0: never). rst pulses at c=rst_at.
  task automatic run_op(input logic [2:0] op, input int rd_dly, input int alu_dly,
                        input int wr_dly, input int hold, input int glitch,
                        input int rst_at, input int ncyc, input logic [MAT_W-1:0] res);
    int a_s;
    int rd_cnt;
    int wr_cnt;
    a_s = -1; rd_cnt = 0; wr_cnt = 0;
    d_cyc = -1; d_n = 0; al_n = 0; rd_n = 0; wr_n = 0; res_bad = 0;
    leds_d = '0; erro_d = '0;
    bus.alu_res  = res;
    bus.alu_done = 1'b0;
    bus.rd_ack   = 1'b0;
    bus.wr_ack   = 1'b0;
    operacao     = op;
    sinal        = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      sinal = (c < hold) && (c != glitch);
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        check_val("rst_busy",      busy,          0);
        check_val("rst_done",      done_o,        0);
        check_val("rst_erro",      erro,          0);
        check_val("rst_count",     op_count,      0);
        check_val("rst_leds",      leds,          0);
        check_val("rst_rd_req",    bus.rd_req,    0);
        check_val("rst_alu_start", bus.alu_start, 0);
        check_val("rst_alu_a",     bus.alu_a,     0);
        check_val("rst_wr_req",    bus.wr_req,    0);
        check_val("rst_mat_res",   bus.mat_res,   0);
      end
      if (c == rst_at + 1) rst = 1'b0;
      if (done_o) begin
        d_n++;
        if (d_cyc < 0) begin
          d_cyc  = c;
          leds_d = leds;
          erro_d = erro;
        end
      end
      if (bus.alu_start) begin
        al_n++;
        a_s = c;
      end
      if (bus.rd_req) begin
        rd_n++;
        rd_cnt++;
      end
      bus.rd_ack = bus.rd_req && (rd_cnt > rd_dly);
      if (bus.wr_req) begin
        wr_n++;
        wr_cnt++;
        if (bus.mat_res !== res) res_bad++;
      end
      bus.wr_ack   = bus.wr_req && (wr_cnt > wr_dly);
      bus.alu_done = (alu_dly >= 0) && (a_s > 0) && (c >= a_s + 1 + alu_dly);
    end
    sinal        = 1'b0;
    bus.rd_ack   = 1'b0;
    bus.wr_ack   = 1'b0;
    bus.alu_done = 1'b0;
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    sinal        = 1'b0;
    operacao     = 3'd0;
    bus.rd_ack   = 1'b0;
    bus.wr_ack   = 1'b0;
    bus.alu_done = 1'b0;
    bus.mat_a_in = C_A;
    bus.mat_b_in = C_B;
    bus.alu_res  = '0;
    tick();
    tick();
    check_val("reset_busy",  busy,     0);
    check_val("reset_leds",  leds,     0);
    check_val("reset_count", op_count, 0);
    check_val("reset_rd",    bus.rd_req, 0);
    rst = 1'b0;
    tick();

    // T1: op 2, everything immediate.
    run_op(3'd2, 0, 0, 0, 3, -1, -1, 10, C_RES1);
    check_val("t1_done_cyc", d_cyc,       6);
    check_val("t1_done_n",   d_n,         1);
    check_val("t1_alu_n",    al_n,        1);
    check_val("t1_rd_n",     rd_n,        1);
    check_val("t1_wr_n",     wr_n,        1);
    check_val("t1_res_bad",  res_bad,     0);
    check_val("t1_mat_res",  bus.mat_res, C_RES1);
    check_val("t1_alu_a",    bus.alu_a,   C_A);
    check_val("t1_alu_b",    bus.alu_b,   C_B);
    check_val("t1_alu_op",   bus.alu_op,  2);
    check_val("t1_count",    op_count,    1);
    check_val("t1_erro",     erro,        0);
    check_val("t1_leds",     leds_d,      9'h143);
    check_val("t1_busy",     busy,        0);

    // T2: opcode 7 is out of range.
    run_op(3'd7, 0, 0, 0, 3, -1, -1, 8, C_RES2);
    check_val("t2_done_cyc", d_cyc,      2);
    check_val("t2_done_n",   d_n,        1);
    check_val("t2_rd_n",     rd_n,       0);
    check_val("t2_alu_n",    al_n,       0);
    check_val("t2_erro_d",   erro_d,     1);
    check_val("t2_erro",     erro,       1);
    check_val("t2_count",    op_count,   1);
    check_val("t2_alu_op",   bus.alu_op, 7);
    check_val("t2_leds",     leds_d,     9'h193);

    // T3: ALU never answers; WAIT_ALU entered at c=4, abort 1023 later.
    run_op(3'd1, 0, -1, 0, 3, -1, -1, 1032, C_RES2);
    check_val("t3_done_cyc", d_cyc,    1027);
    check_val("t3_wr_n",     wr_n,     0);
    check_val("t3_erro",     erro,     2);
    check_val("t3_count",    op_count, 1);
    check_val("t3_leds",     leds_d,   9'h1A3);
    check_val("t3_mat_res",  bus.mat_res, C_RES1);
    run_op(3'd0, 0, 0, 0, 3, -1, -1, 10, C_RES2);
    check_val("t3b_erro",    erro,     0);
    check_val("t3b_count",   op_count, 2);
    check_val("t3b_done_cyc", d_cyc,   6);

    // T4: slow fetch ack (4) and slow write ack (3).
    run_op(3'd4, 4, 0, 3, 3, -1, -1, 18, C_RES1);
    check_val("t4_done_cyc", d_cyc,       13);
    check_val("t4_rd_n",     rd_n,        5);
    check_val("t4_wr_n",     wr_n,        4);
    check_val("t4_res_bad",  res_bad,     0);
    check_val("t4_mat_res",  bus.mat_res, C_RES1);
    check_val("t4_count",    op_count,    3);

    // T5: sinal held for 50 cycles, then a second edge while busy.
    run_op(3'd5, 0, 0, 0, 50, -1, -1, 60, C_RES2);
    check_val("t5_hold_done_n", d_n,      1);
    check_val("t5_hold_count",  op_count, 4);
    run_op(3'd6, 4, 0, 0, 50, 3, -1, 60, C_RES2);
    check_val("t5_glitch_done_n", d_n,    1);
    check_val("t5_glitch_cyc",    d_cyc,  10);
    check_val("t5_glitch_count",  op_count, 5);

    // T6: reset while in WAIT_ALU, then a clean run.
    run_op(3'd3, 0, -1, 0, 3, -1, 10, 20, C_RES1);
    check_val("t6_done_n", d_n,      0);
    check_val("t6_count",  op_count, 0);
    run_op(3'd3, 0, 0, 0, 3, -1, -1, 10, C_RES1);
    check_val("t6_clean_cyc",   d_cyc,    6);
    check_val("t6_clean_count", op_count, 1);
    check_val("t6_clean_res",   bus.mat_res, C_RES1);

    // T5 wrap: 256 successful ops since reset wrap the counter to 0.
    for (int i = 0; i < 254; i++) begin
      run_op(3'(i % 7), 0, 0, 0, 3, -1, -1, 8, C_RES2);
    end
    check_val("wrap_255", op_count, 255);
    run_op(3'd1, 0, 0, 0, 3, -1, -1, 8, C_RES2);
    check_val("wrap_0",    op_count, 0);
    check_val("wrap_erro", erro,     0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
